// File: rtl/clock_divider_multi_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int MIN_DIV = 2;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } ch_state_e;

  function automatic logic [31:0] clamp_div(input logic [31:0] ratio);
    return (ratio < 32'(MIN_DIV)) ? 32'(MIN_DIV) : ratio;
  endfunction

endpackage

// File: rtl/clock_divider_multi_if.sv
// Control/status bundle for clock_divider_multi: per-channel enables, ratio loads and divided outputs.
interface clock_divider_multi_if #(
  parameter int N_CH  = 4,
  parameter int DIV_W = 16
);
  logic [N_CH-1:0]       en;
  logic [N_CH-1:0]       load;
  logic [N_CH*DIV_W-1:0] div_value;
  logic [N_CH-1:0]       clock_out;
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       pending;

  modport master (output en, load, div_value, input clock_out, tick, pending);
  modport slave  (input en, load, div_value, output clock_out, tick, pending);
endinterface

// File: rtl/clock_divider_multi_ch.sv
// One divider channel: period counter, STOPPED/RUNNING FSM and shadow ratio register.
// Optional CLKDIV_SYNC_EN adds a sync_i input that restarts the period on demand.
module clock_divider_ch
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             global_clock,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_i,
`endif
  output logic             clock_o,
  output logic             tick_o,
  output logic             pending_o
);

  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(clamp_div(32'(DEFAULT_DIV)));

  ch_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] d_act_q, d_act_d;
  logic [DIV_W-1:0] d_pend_q, d_pend_d;
  logic             pending_q, pending_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic [DIV_W-1:0] load_div, next_div, cnt_inc, high_len;
  logic [DIV_W:0]   high_ext;
  logic             wrap, sync_hit;

`ifdef CLKDIV_SYNC_EN
  assign sync_hit = sync_i & en_i;
`else
  assign sync_hit = 1'b0;
`endif

  assign load_div = DIV_W'(clamp_div(32'(div_i)));
  // A load landing on a boundary edge bypasses the shadow register.
  assign next_div = load_i ? load_div : (pending_q ? d_pend_q : d_act_q);
  assign high_ext = ({1'b0, d_act_q} + (DIV_W+1)'(1)) >> 1;
  assign high_len = high_ext[DIV_W-1:0];
  assign cnt_inc  = cnt_q + DIV_W'(1);
  assign wrap     = (cnt_q == d_act_q - DIV_W'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    d_act_d   = d_act_q;
    d_pend_d  = d_pend_q;
    pending_d = pending_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;

    if (load_i) begin
      d_pend_d  = load_div;
      pending_d = 1'b1;
    end

    if (sync_hit || (state_q == STOPPED && en_i) || (state_q == RUNNING && wrap && en_i)) begin
      state_d   = RUNNING;
      cnt_d     = '0;
      clk_d     = 1'b1;
      tick_d    = 1'b1;
      d_act_d   = next_div;
      pending_d = 1'b0;
    end else if (state_q == RUNNING && wrap) begin
      state_d   = STOPPED;
      cnt_d     = '0;
      clk_d     = 1'b0;
      d_act_d   = next_div;
      pending_d = 1'b0;
    end else if (state_q == RUNNING) begin
      cnt_d = cnt_inc;
      clk_d = (cnt_inc < high_len);
    end
  end

  always_ff @(posedge global_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= STOPPED;
      cnt_q     <= '0;
      d_act_q   <= RESET_DIV;
      d_pend_q  <= '0;
      pending_q <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      d_act_q   <= d_act_d;
      d_pend_q  <= d_pend_d;
      pending_q <= pending_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

  assign clock_o   = clk_q;
  assign tick_o    = tick_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/clock_divider_multi.sv
// N-channel programmable clock divider; each channel runs independently from global_clock.
// Optional CLKDIV_SYNC_EN adds a sync input that phase-aligns all enabled channels.
module clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 5
) (
  input  logic                 global_clock,
  input  logic                 reset_n,
`ifdef CLKDIV_SYNC_EN
  input  logic                 sync,
`endif
  clock_divider_multi_if.slave bus
);

  logic [N_CH-1:0] clk_vec, tick_vec, pend_vec;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      clock_divider_ch #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
        .global_clock (global_clock),
        .reset_n      (reset_n),
        .en_i         (bus.en[gi]),
        .load_i       (bus.load[gi]),
        .div_i        (bus.div_value[gi*DIV_W +: DIV_W]),
`ifdef CLKDIV_SYNC_EN
        .sync_i       (sync),
`endif
        .clock_o      (clk_vec[gi]),
        .tick_o       (tick_vec[gi]),
        .pending_o    (pend_vec[gi])
      );
    end
  endgenerate

  assign bus.clock_out = clk_vec;
  assign bus.tick      = tick_vec;
  assign bus.pending   = pend_vec;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi; sync phase-alignment steps run when CLKDIV_SYNC_EN is defined.
module tb_clock_divider_multi;

  localparam int N_CH  = 4;
  localparam int DIV_W = 16;

  logic global_clock;
  logic reset_n;
`ifdef CLKDIV_SYNC_EN
  logic sync;
`endif
  int checks = 0;
  int errors = 0;

  clock_divider_multi_if #(.N_CH(N_CH), .DIV_W(DIV_W)) bus ();

  clock_divider_multi #(.N_CH(N_CH), .DIV_W(DIV_W), .DEFAULT_DIV(5)) dut (
    .global_clock (global_clock),
    .reset_n      (reset_n),
`ifdef CLKDIV_SYNC_EN
    .sync         (sync),
`endif
    .bus          (bus)
  );

  initial global_clock = 1'b0;
  always #5 global_clock = ~global_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_div(input int ch, input logic [DIV_W-1:0] v);
    bus.div_value[ch*DIV_W +: DIV_W] = v;
  endtask

  // Patterns are written left-to-right in time: MSB of the n-bit field is the first cycle.
  task automatic run_ch(input string tag, input int ch, input int n,
                        input logic [31:0] cp, input logic [31:0] tp, input logic [31:0] pp);
    for (int i = 0; i < n; i++) begin
      @(negedge global_clock);
      $display("%s ch%0d cyc%0d: clock_out=%b tick=%b pending=%b", tag, ch, i,
               bus.clock_out[ch], bus.tick[ch], bus.pending[ch]);
      chk($sformatf("%s_clk[%0d]", tag, i), 32'(bus.clock_out[ch]), 32'(cp[n-1-i]));
      chk($sformatf("%s_tick[%0d]", tag, i), 32'(bus.tick[ch]), 32'(tp[n-1-i]));
      chk($sformatf("%s_pend[%0d]", tag, i), 32'(bus.pending[ch]), 32'(pp[n-1-i]));
    end
  endtask

  initial begin
    bus.en        = '0;
    bus.load      = '0;
    bus.div_value = '0;
    reset_n       = 1'b0;
`ifdef CLKDIV_SYNC_EN
    sync          = 1'b0;
`endif
    repeat (3) @(negedge global_clock);
    chk("rst_clk", 32'(bus.clock_out), 32'h0);
    chk("rst_tick", 32'(bus.tick), 32'h0);
    chk("rst_pend", 32'(bus.pending), 32'h0);
    reset_n = 1'b1;
    @(negedge global_clock);
    chk("idle_clk", 32'(bus.clock_out), 32'h0);

    // Default ratio 5: 3 high / 2 low, first tick one edge after enable.
    bus.en[0] = 1'b1;
    run_ch("t1", 0, 10, 32'b1110011100, 32'b1000010000, 32'b0);

    // Load 4 at cnt=1: current period of 5 completes, then period 4.
    run_ch("t2a", 0, 2, 32'b11, 32'b10, 32'b0);
    set_div(0, 16'd4); bus.load[0] = 1'b1;
    @(negedge global_clock);
    chk("t2_load_clk", 32'(bus.clock_out[0]), 32'h1);
    chk("t2_load_pend", 32'(bus.pending[0]), 32'h1);
    bus.load[0] = 1'b0;
    run_ch("t2b", 0, 10, 32'b0011001100, 32'b0010001000, 32'b1100000000);

    // Ratio 0 loaded on the wrap edge clamps to 2, applied directly.
    set_div(0, 16'd0); bus.load[0] = 1'b1;
    @(negedge global_clock);
    chk("t3_d0_tick", 32'(bus.tick[0]), 32'h1);
    chk("t3_d0_pend", 32'(bus.pending[0]), 32'h0);
    bus.load[0] = 1'b0;
    run_ch("t3a", 0, 4, 32'b0101, 32'b0101, 32'b0);
    // Ratio 1 mid-period: pending for one cycle, then period 2.
    set_div(0, 16'd1); bus.load[0] = 1'b1;
    @(negedge global_clock);
    chk("t3_d1_clk", 32'(bus.clock_out[0]), 32'h0);
    chk("t3_d1_pend", 32'(bus.pending[0]), 32'h1);
    bus.load[0] = 1'b0;
    run_ch("t3b", 0, 4, 32'b1010, 32'b1010, 32'b0);
    // Ratio 7 on the wrap edge: applied at once, pending never set.
    set_div(0, 16'd7); bus.load[0] = 1'b1;
    @(negedge global_clock);
    chk("t3_d7_tick", 32'(bus.tick[0]), 32'h1);
    chk("t3_d7_pend", 32'(bus.pending[0]), 32'h0);
    bus.load[0] = 1'b0;
    run_ch("t3c", 0, 7, 32'b1110001, 32'b0000001, 32'b0);

    // Move to ratio 6, then drop enable in the high phase.
    set_div(0, 16'd6); bus.load[0] = 1'b1;
    @(negedge global_clock);
    chk("t4_load_pend", 32'(bus.pending[0]), 32'h1);
    bus.load[0] = 1'b0;
    run_ch("t4a", 0, 6, 32'b110001, 32'b000001, 32'b111110);
    bus.en[0] = 1'b0;
    run_ch("t4b", 0, 12, 32'b110000000000, 32'b0, 32'b0);
    bus.en[0] = 1'b1;
    run_ch("t4c", 0, 7, 32'b1110001, 32'b1000001, 32'b0);
    chk("t4_others_clk", 32'(bus.clock_out[3:1]), 32'h0);
    chk("t4_others_tick", 32'(bus.tick[3:1]), 32'h0);

    // All channels running, one with a pending ratio, then async reset mid high phase.
    bus.en = 4'hF;
    @(negedge global_clock);
    chk("t5_start_clk", 32'(bus.clock_out), 32'hF);
    chk("t5_start_tick", 32'(bus.tick), 32'hE);
    set_div(3, 16'd9); bus.load = 4'b1000;
    @(negedge global_clock);
    chk("t5_pend_pre", 32'(bus.pending), 32'h8);
    chk("t5_clk_pre", 32'(bus.clock_out), 32'hF);
    bus.load = '0;
    reset_n = 1'b0;
    #1;
    chk("t5_async_clk", 32'(bus.clock_out), 32'h0);
    chk("t5_async_tick", 32'(bus.tick), 32'h0);
    chk("t5_async_pend", 32'(bus.pending), 32'h0);
    repeat (2) @(negedge global_clock);
    reset_n = 1'b1;
    @(negedge global_clock);
    chk("t5_restart_clk", 32'(bus.clock_out), 32'hF);
    chk("t5_restart_tick", 32'(bus.tick), 32'hF);
    run_ch("t5", 0, 5, 32'b11001, 32'b00001, 32'b0);
    chk("t5_all_tick", 32'(bus.tick), 32'hF);

`ifdef CLKDIV_SYNC_EN
    // ch0 ratio 3, ch1 ratio 6; sync applies both and aligns their phase.
    set_div(0, 16'd3); set_div(1, 16'd6); bus.load = 4'b0011;
    @(negedge global_clock);
    bus.load = '0;
    sync = 1'b1;
    @(negedge global_clock);
    sync = 1'b0;
    chk("t6_sync_clk", 32'(bus.clock_out[1:0]), 32'h3);
    chk("t6_sync_tick", 32'(bus.tick[1:0]), 32'h3);
    chk("t6_sync_pend", 32'(bus.pending[1:0]), 32'h0);
    begin
      logic [11:0] c0, t0, c1, t1;
      c0 = 12'b101101101101; t0 = 12'b001001001001;
      c1 = 12'b110001110001; t1 = 12'b000001000001;
      for (int i = 0; i < 12; i++) begin
        @(negedge global_clock);
        $display("t6 cyc%0d: clock_out=%b tick=%b", i, bus.clock_out[1:0], bus.tick[1:0]);
        chk($sformatf("t6_ch0_clk[%0d]", i), 32'(bus.clock_out[0]), 32'(c0[11-i]));
        chk($sformatf("t6_ch0_tick[%0d]", i), 32'(bus.tick[0]), 32'(t0[11-i]));
        chk($sformatf("t6_ch1_clk[%0d]", i), 32'(bus.clock_out[1]), 32'(c1[11-i]));
        chk($sformatf("t6_ch1_tick[%0d]", i), 32'(bus.tick[1]), 32'(t1[11-i]));
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- N-channel programmable clock divider driven from the FPGA global clock.
- Each channel produces a registered divided clock with a run-time divide ratio, plus a one-cycle tick strobe at each output rising edge.
- Ratio changes are applied only at the channel's period boundary.
- Enable and disable are glitch-free; a channel always completes its current period before stopping.
- Feeds ADC sampling clocks, trigger logic timing and slow-control strobes.

Parameters:
- N_CH, 4, number of independent output channels.
- DIV_W, 16, width of each divide ratio field.
- DEFAULT_DIV, 5, divide ratio loaded into every channel at reset (clamped to at least 2).

Ports:
- global_clock  in  1  single system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  N_CH  per-channel run enable.
- load  in  N_CH  per-channel strobe: capture that channel's div_value field.
- div_value  in  N_CH*DIV_W  ratios; channel k occupies bits [k*DIV_W +: DIV_W].
- clock_out  out  N_CH  divided clocks, registered.
- tick  out  N_CH  one-cycle pulse, registered, coincident with each clock_out 0->1.
- pending  out  N_CH  a loaded ratio is waiting for the next period boundary.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - cnt=0, clock_out=0, tick=0, pending=0, running=0.
  - D_act=clamp(DEFAULT_DIV), D_pend=0.
- Clamp rule: any ratio value <2 is treated as 2. DIV_W-bit unsigned arithmetic; no overflow, since cnt never exceeds D_act-1.
- Waveform:
  - Period is exactly D_act global_clock cycles.
  - Output is high for H=ceil(D_act/2) cycles, then low for D_act-H cycles.
  - Internal compare: clock_out <= (cnt_next < H).
- Per-channel states: STOPPED, RUNNING.
- STOPPED:
  - clock_out=0, cnt held at 0.
  - On an edge sampling en=1: go to RUNNING with cnt<=0, clock_out<=1, tick<=1. The first output rising edge is 1 cycle after en is sampled.
  - Any pending ratio is applied on that same edge.
- RUNNING:
  - Each edge: cnt <= (cnt==D_act-1) ? 0 : cnt+1.
  - tick<=1 only on the wrap edge.
- Wrap edge with en=0: go to STOPPED with cnt<=0, clock_out<=0, tick<=0. No truncated high or low phase is ever emitted.
- en dropping then returning before the wrap edge: no disruption to the waveform.
- Ratio load:
  - load[k]=1 captures the field into D_pend and sets pending=1.
  - At the next wrap edge (or STOPPED->RUNNING edge): D_act<=D_pend, pending<=0.
  - load coincident with the wrap edge: div_value is applied directly on that edge and pending stays 0.
  - Repeated loads before the boundary: last value wins.
- Channels are fully independent; no cross-channel coupling except the optional sync.
- Reset asserted mid-period: all outputs go to 0 immediately (asynchronous). Deassertion is synchronised externally by the reset tree.

Optional Feature:
- CLKDIV_SYNC_EN defined:
  - Adds input port sync (1 bit).
  - An edge sampling sync=1 forces every channel with en=1 to cnt<=0, clock_out<=1, tick<=1.
  - Pending ratios are applied on that edge; STOPPED channels with en=1 start on it.
  - Use: phase-align all channels.
  - sync has priority over normal wrap/stop processing.
- CLKDIV_SYNC_EN undefined: no sync port and no sync logic; channels run free-phase.

Decomposition:
- Package clkdiv_pkg holds:
  - MIN_DIV=2.
  - The clamp function (ratio -> max(ratio, MIN_DIV)).
  - The state encoding STOPPED=1'b0, RUNNING=1'b1.
- Sub-module clock_divider_ch:
  - One channel: counter, FSM, shadow ratio register.
  - Top instantiates N_CH copies in a generate loop and slices the buses.

Test Plan:
- Reset, DEFAULT_DIV=5, en[0]=1 -> clock_out[0] high 3 cycles, low 2 cycles; tick every 5 cycles; first tick 1 cycle after en sampled.
- While running at D=5, load D=4 at cnt=1 -> pending=1 until the wrap edge; the current 5-cycle period completes, then a 2-high/2-low waveform with tick period 4.
- Load D=0, then D=1 -> both produce period 2 (1 high/1 low); load D=7 coincident with the wrap edge -> applied immediately, pending never set.
- en[0] deasserted during the high phase at D=6 -> period finishes (3 high, 3 low), then clock_out stays 0 with no further tick; re-enable -> tick on the next edge.
- reset_n pulled low mid high phase on all channels -> clock_out, tick and pending all 0 within the same cycle; after release, channels restart from DEFAULT_DIV when enabled.
- CLKDIV_SYNC_EN, ch0 D=3, ch1 D=6, free-running, sync pulse -> both tick on the same edge, then ch0 ticks twice for every ch1 tick, with rising edges aligned.
